// File: rtl/ptp_ts_reg_reader.sv
// PTP timestamp FIFO with a req/ack register responder; read ack comes 2 cycles after req is seen in IDLE.
// Optional PTP_TS_IRQ_EN adds an interrupt enable (STATUS bit8) and a registered ts_irq output.
module ptp_ts_reg_reader #(
  parameter int TS_DEPTH_BITS  = 3,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ts_valid,
  input  logic [31:0] ts_hi,
  input  logic [31:0] ts_lo,
  input  logic        reg_req,
  input  logic        reg_rd_wr_L,
  input  logic [1:0]  reg_addr,
  input  logic [31:0] reg_wr_data,
  output logic [31:0] reg_rd_data,
  output logic        reg_ack,
`ifdef PTP_TS_IRQ_EN
  output logic        ts_irq,
`endif
  output logic        ts_avail
);

  localparam int DEPTH = 1 << TS_DEPTH_BITS;
  localparam logic [TS_DEPTH_BITS:0] CNT_FULL = (TS_DEPTH_BITS+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT} state_t;

  state_t                    state;
  logic [63:0]               mem [DEPTH];
  logic [TS_DEPTH_BITS-1:0]  wr_ptr, rd_ptr;
  logic [TS_DEPTH_BITS:0]    count, count_nxt;
  logic                      overflow, overflow_nxt;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt, drop_cnt_nxt;
  logic [31:0]               rd_stage, rd_mux, status;
  logic [63:0]               head;
  logic                      irq_en;
  logic                      full, empty, decode, rd, wr;
  logic                      push, pop, drop, flush, clr_ovf, clr_drops;
  logic                      lint_unused;

  assign lint_unused = ^reg_wr_data;

  always_comb begin
    full      = (count == CNT_FULL);
    empty     = (count == '0);
    decode    = (state == S_IDLE) && reg_req;
    rd        = decode && reg_rd_wr_L;
    wr        = decode && !reg_rd_wr_L;
    pop       = rd && (reg_addr == 2'd2) && !empty;
    flush     = wr && (reg_addr == 2'd0) && reg_wr_data[1];
    clr_ovf   = wr && (reg_addr == 2'd0) && reg_wr_data[0];
    clr_drops = wr && (reg_addr == 2'd3);
    // A pop in the same cycle frees the slot, so a full FIFO still takes the event.
    push      = ts_valid && !flush && (!full || pop);
    drop      = ts_valid && !flush && full && !pop;

    count_nxt = flush ? '0
              : count + (TS_DEPTH_BITS+1)'(push) - (TS_DEPTH_BITS+1)'(pop);
    overflow_nxt = (overflow && !clr_ovf) || drop;
    drop_cnt_nxt = drop_cnt;
    if (clr_drops)
      drop_cnt_nxt = '0;
    else if (drop && !(&drop_cnt))
      drop_cnt_nxt = drop_cnt + DROP_CNT_WIDTH'(1);

    head   = mem[rd_ptr];
    status = '0;
    status[31] = overflow;
    status[30] = full;
    status[29] = empty;
    status[8]  = irq_en;
    status[TS_DEPTH_BITS:0] = count;

    rd_mux = '0;
    if (reg_rd_wr_L) begin
      case (reg_addr)
        2'd0: rd_mux = status;
        2'd1: rd_mux = empty ? 32'd0 : head[63:32];
        2'd2: rd_mux = empty ? 32'd0 : head[31:0];
        default: rd_mux = 32'(drop_cnt);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {ts_hi, ts_lo};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      ts_avail <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + TS_DEPTH_BITS'(1);
        if (pop)  rd_ptr <= rd_ptr + TS_DEPTH_BITS'(1);
      end
      count    <= count_nxt;
      overflow <= overflow_nxt;
      drop_cnt <= drop_cnt_nxt;
      ts_avail <= (count_nxt != '0);
    end
  end

`ifdef PTP_TS_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en <= 1'b0;
      ts_irq <= 1'b0;
    end else begin
      if (wr && (reg_addr == 2'd0))
        irq_en <= reg_wr_data[8];
      ts_irq <= irq_en && ((count_nxt != '0) || overflow_nxt);
    end
  end
`else
  assign irq_en = 1'b0;
`endif

  // Read data is staged at decode and only presented alongside the ack pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      rd_stage    <= '0;
      reg_ack     <= 1'b0;
      reg_rd_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          reg_ack     <= 1'b0;
          reg_rd_data <= '0;
          if (reg_req) begin
            rd_stage <= rd_mux;
            state    <= S_ACK;
          end
        end
        S_ACK: begin
          reg_ack     <= 1'b1;
          reg_rd_data <= rd_stage;
          state       <= S_WAIT;
        end
        default: begin
          reg_ack     <= 1'b0;
          reg_rd_data <= '0;
          if (!reg_req)
            state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ptp_ts_reg_reader.sv
// Directed bench for ptp_ts_reg_reader; drop counter narrowed to 8 bits so saturation is reachable quickly.
module tb_ptp_ts_reg_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        ts_valid;
  logic [31:0] ts_hi, ts_lo;
  logic        reg_req, reg_rd_wr_L;
  logic [1:0]  reg_addr;
  logic [31:0] reg_wr_data;
  logic [31:0] reg_rd_data;
  logic        reg_ack;
  logic        ts_avail;
`ifdef PTP_TS_IRQ_EN
  logic        ts_irq;
`endif

  int total = 0;
  int bad   = 0;

  ptp_ts_reg_reader #(.TS_DEPTH_BITS(3), .DROP_CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .ts_valid(ts_valid), .ts_hi(ts_hi), .ts_lo(ts_lo),
    .reg_req(reg_req), .reg_rd_wr_L(reg_rd_wr_L), .reg_addr(reg_addr),
    .reg_wr_data(reg_wr_data), .reg_rd_data(reg_rd_data), .reg_ack(reg_ack),
`ifdef PTP_TS_IRQ_EN
    .ts_irq(ts_irq),
`endif
    .ts_avail(ts_avail)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // One register access; inj drives a timestamp event exactly on the decode edge.
  task automatic access(input logic is_rd, input logic [1:0] a, input logic [31:0] wd,
                        input logic inj, output logic [31:0] d);
    int lat;
    lat = 0;
    d = '0;
    reg_req = 1'b1; reg_rd_wr_L = is_rd; reg_addr = a; reg_wr_data = wd;
    if (inj) begin
      ts_valid = 1'b1; ts_hi = 32'hAA; ts_lo = 32'hBB;
    end
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(posedge clk); #1;
      ts_valid = 1'b0;
      if (reg_ack) begin
        lat = i;
        d = reg_rd_data;
      end
    end
    reg_req = 1'b0;
    chk("ack_latency", lat, 2);
    @(posedge clk); #1;
    chk("ack_one_cycle", {31'd0, reg_ack}, 0);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    access(1'b1, a, 32'd0, 1'b0, d);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] wd);
    logic [31:0] dummy;
    access(1'b0, a, wd, 1'b0, dummy);
  endtask

  task automatic push(input logic [31:0] hi, input logic [31:0] lo);
    ts_valid = 1'b1; ts_hi = hi; ts_lo = lo;
    @(posedge clk); #1;
    ts_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    int acks;
    reset = 1'b1; ts_valid = 1'b0; ts_hi = '0; ts_lo = '0;
    reg_req = 1'b0; reg_rd_wr_L = 1'b1; reg_addr = '0; reg_wr_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    chk("rst_ack", {31'd0, reg_ack}, 0);
    chk("rst_rdata", reg_rd_data, 0);
    chk("rst_avail", {31'd0, ts_avail}, 0);
    rd(2'd0, d); chk("rst_status", d, 32'h2000_0000);

    // single event round trip
    push(32'h0000_0001, 32'h89AB_CDEF);
    chk("avail_after_push", {31'd0, ts_avail}, 1);
    rd(2'd1, d); chk("ts_hi", d, 32'h0000_0001);
    rd(2'd2, d); chk("ts_lo", d, 32'h89AB_CDEF);
    rd(2'd0, d); chk("status_empty", d, 32'h2000_0000);
    chk("avail_after_pop", {31'd0, ts_avail}, 0);

    // overflow: 9 events into 8 entries
    for (int i = 0; i < 9; i++) push(32'(i), 32'h100 + 32'(i));
    rd(2'd0, d); chk("status_full_ovf", d, 32'hC000_0008);
    rd(2'd3, d); chk("drops_one", d, 32'd1);
    wr(2'd0, 32'h1);
    rd(2'd0, d); chk("ovf_cleared", d, 32'h4000_0008);
    wr(2'd3, 32'h0);
    rd(2'd3, d); chk("drops_cleared", d, 32'd0);

    // full FIFO, push concurrent with TS_LO pop
    access(1'b1, 2'd2, 32'd0, 1'b1, d); chk("pop_with_push", d, 32'h100);
    rd(2'd0, d); chk("still_full", d, 32'h4000_0008);
    rd(2'd3, d); chk("no_drop", d, 32'd0);
    for (int i = 1; i < 8; i++) begin
      rd(2'd1, d); chk("drain_hi", d, 32'(i));
      rd(2'd2, d); chk("drain_lo", d, 32'h100 + 32'(i));
    end
    rd(2'd1, d); chk("tail_hi", d, 32'hAA);
    rd(2'd2, d); chk("tail_lo", d, 32'hBB);

    // empty TS_LO read
    rd(2'd2, d); chk("empty_lo", d, 32'd0);
    rd(2'd0, d); chk("empty_status", d, 32'h2000_0000);

    // held request: one ack, one pop
    push(32'h11, 32'h22);
    push(32'h33, 32'h44);
    acks = 0;
    reg_req = 1'b1; reg_rd_wr_L = 1'b1; reg_addr = 2'd2;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (reg_ack) acks++;
    end
    reg_req = 1'b0;
    @(posedge clk); #1;
    chk("held_acks", acks, 1);
    rd(2'd0, d); chk("held_count", d, 32'h0000_0001);
    rd(2'd1, d); chk("held_next_hi", d, 32'h33);
    rd(2'd2, d); chk("held_next_lo", d, 32'h44);

    // drop counter saturation and clear-vs-drop
    for (int i = 0; i < 8; i++) push(32'(i), 32'(i));
    ts_valid = 1'b1;
    repeat (260) @(posedge clk);
    #1 ts_valid = 1'b0;
    rd(2'd3, d); chk("drops_sat", d, 32'hFF);
    push(32'h5, 32'h5);
    rd(2'd3, d); chk("drops_stay_sat", d, 32'hFF);
    access(1'b0, 2'd3, 32'd0, 1'b1, d);
    rd(2'd3, d); chk("clear_beats_drop", d, 32'd0);

    // flush with concurrent event: discarded, not a drop
    access(1'b0, 2'd0, 32'h2, 1'b1, d);
    rd(2'd0, d); chk("flush_status", d, 32'hA000_0000);
    rd(2'd3, d); chk("flush_no_drop", d, 32'd0);
    chk("flush_avail", {31'd0, ts_avail}, 0);

    // irq enable bit
    wr(2'd0, 32'h101);
`ifdef PTP_TS_IRQ_EN
    rd(2'd0, d); chk("irq_en_status", d, 32'h2000_0100);
    chk("irq_idle", {31'd0, ts_irq}, 0);
    push(32'h7, 32'h8);
    @(posedge clk); #1;
    chk("irq_set", {31'd0, ts_irq}, 1);
    rd(2'd2, d); chk("irq_pop_lo", d, 32'h8);
    chk("irq_clear", {31'd0, ts_irq}, 0);
    wr(2'd0, 32'h0);
`else
    rd(2'd0, d); chk("bit8_ignored", d, 32'h2000_0000);
`endif

    // reset while the responder is in ACK
    push(32'h9, 32'h9);
    reg_req = 1'b1; reg_rd_wr_L = 1'b1; reg_addr = 2'd2;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ack", {31'd0, reg_ack}, 0);
    reset = 1'b0; reg_req = 1'b0;
    @(posedge clk); #1;
    chk("rst_no_late_ack", {31'd0, reg_ack}, 0);
    chk("rst_avail2", {31'd0, ts_avail}, 0);
    rd(2'd0, d); chk("rst_status2", d, 32'h2000_0000);
    rd(2'd3, d); chk("rst_drops2", d, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
